ir_receiver: RTL

IrDA SIR receive stage that consumes the pulse stream produced by `ir_transmitter` (`tx_data_out`) and recovers the 8-bit payload. It synchronises the raw IR line, times bit windows against a 16x oversample tick, demodulates each window (pulse present = 0, no pulse = 1), checks even parity and the stop bit, and presents each byte with a one-cycle strobe. It sits between the IR photodiode input pin and the UART-side consumer logic.

---
 rtl/ir_receiver_pkg.sv | 23 ++
 rtl/ir_oversample_tick.sv | 39 +++
 rtl/ir_receiver.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_receiver_pkg.sv
// Shared IrDA SIR receive definitions: frame geometry, FSM encoding and parity helper.
package ir_receiver_pkg;

    localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
    localparam int OVERSAMPLE = 16;   // ticks per bit period
    localparam int HALF_BIT   = 8;    // ticks from start accept to mid start bit
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    // Even parity bit for a data byte: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ir_oversample_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks while enabled.
// After restart the first tick is consumed exactly TICK_DIV clocks later.
module ir_oversample_tick #(
    parameter int TICK_DIV = 325
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Divider counter; tick is registered one count early so it lines up with the wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (enable) begin
            cnt_r  <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
            tick_r <= (cnt_r == CNT_PRE);
        end else begin
            cnt_r  <= cnt_r;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ir_receiver.sv
// IrDA SIR receiver: synchronises the raw IR line, filters the start pulse,
// demodulates 16-tick bit windows (pulse = 0) and delivers each byte with
// parity/framing status and a one-cycle strobe.
module ir_receiver
    import ir_receiver_pkg::*;
#(
    parameter int TICK_DIV  = 325,
    parameter int MIN_PULSE = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 rx_busy
);

    localparam int                HI_W       = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
    localparam logic [HI_W-1:0]   HI_LAST    = HI_W'(MIN_PULSE - 1);
    localparam int                TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] START_LAST = TICK_W'(HALF_BIT - 1);
    localparam logic [TICK_W-1:0] WIN_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam int                IDX_W      = $clog2(FRAME_BITS);
    localparam int                DIDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_BITS - 1);

    // Synchroniser; rx_sync_r is the synchronised line (rx_s) used everywhere.
    logic rx_meta_r;
    logic rx_sync_r;

    rx_state_e state_r, state_s;

    logic [HI_W-1:0]      hi_cnt_r,       hi_cnt_s;
    logic [TICK_W-1:0]    tick_cnt_r,     tick_cnt_s;
    logic [IDX_W-1:0]     bit_idx_r,      bit_idx_s;
    logic                 latch_r,        latch_s;
    logic [DATA_BITS-1:0] shift_r,        shift_s;
    logic                 parity_bit_r,   parity_bit_s;
    logic                 frame_err_r,    frame_err_s;
    logic [DATA_BITS-1:0] data_r,         data_s;
    logic                 data_valid_r,   data_valid_s;
    logic                 parity_error_r, parity_error_s;
    logic                 frame_error_r,  frame_error_s;
    logic                 rx_busy_r,      rx_busy_s;

    logic tick_s;
    logic enable_s;
    logic restart_s;
    logic hit_s;
    logic rx_bit_s;
    logic start_end_s;
    logic win_end_s;

    assign enable_s    = (state_r != ST_IDLE);
    assign hit_s       = latch_r | rx_sync_r;
    assign rx_bit_s    = ~hit_s;
    assign start_end_s = tick_s && (tick_cnt_r == START_LAST);
    assign win_end_s   = tick_s && (tick_cnt_r == WIN_LAST);

    ir_oversample_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable_s),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-stage synchroniser for the asynchronous IR line.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Tick counter within the current window and the pulse latch that records any high cycle.
    always_comb begin
        tick_cnt_s = tick_cnt_r;
        latch_s    = latch_r;
        case (state_r)
            ST_START: begin
                if (start_end_s) begin
                    tick_cnt_s = '0;
                    latch_s    = 1'b0;
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    latch_s    = hit_s;
                end else begin
                    latch_s    = hit_s;
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (win_end_s) begin
                    tick_cnt_s = '0;
                    latch_s    = 1'b0;
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    latch_s    = hit_s;
                end else begin
                    latch_s    = hit_s;
                end
            end
            default: begin
                tick_cnt_s = '0;
                latch_s    = 1'b0;
            end
        endcase
    end

    // Frame FSM next state, data assembly and output updates.
    always_comb begin
        state_s        = state_r;
        hi_cnt_s       = '0;
        bit_idx_s      = bit_idx_r;
        shift_s        = shift_r;
        parity_bit_s   = parity_bit_r;
        frame_err_s    = frame_err_r;
        data_s         = data_r;
        parity_error_s = parity_error_r;
        frame_error_s  = frame_error_r;
        data_valid_s   = 1'b0;
        restart_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_idx_s = '0;
                if (rx_sync_r) begin
                    if (hi_cnt_r == HI_LAST) begin
                        state_s   = ST_START;
                        restart_s = 1'b1;
                    end else begin
                        hi_cnt_s  = hi_cnt_r + HI_W'(1);
                    end
                end else begin
                    hi_cnt_s = '0;
                end
            end
            ST_START: begin
                if (start_end_s) begin
                    state_s   = ST_DATA;
                    bit_idx_s = '0;
                end else begin
                    state_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (win_end_s) begin
                    shift_s[bit_idx_r[DIDX_W-1:0]] = rx_bit_s;
                    bit_idx_s = bit_idx_r + IDX_W'(1);
                    if (bit_idx_r == DATA_LAST) begin
                        state_s = ST_PARITY;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (win_end_s) begin
                    parity_bit_s = rx_bit_s;
                    state_s      = ST_STOP;
                end else begin
                    state_s      = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (win_end_s) begin
                    frame_err_s = hit_s;
                    state_s     = ST_DONE;
                end else begin
                    state_s     = ST_STOP;
                end
            end
            ST_DONE: begin
                data_s         = shift_r;
                parity_error_s = even_parity(shift_r) ^ parity_bit_r;
                frame_error_s  = frame_err_r;
                data_valid_s   = 1'b1;
                state_s        = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Busy covers the accept edge through the strobe cycle inclusive.
        rx_busy_s = (state_s != ST_IDLE) || (state_r == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            hi_cnt_r       <= '0;
            tick_cnt_r     <= '0;
            bit_idx_r      <= '0;
            latch_r        <= 1'b0;
            shift_r        <= '0;
            parity_bit_r   <= 1'b0;
            frame_err_r    <= 1'b0;
            data_r         <= '0;
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
            frame_error_r  <= 1'b0;
            rx_busy_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            hi_cnt_r       <= hi_cnt_s;
            tick_cnt_r     <= tick_cnt_s;
            bit_idx_r      <= bit_idx_s;
            latch_r        <= latch_s;
            shift_r        <= shift_s;
            parity_bit_r   <= parity_bit_s;
            frame_err_r    <= frame_err_s;
            data_r         <= data_s;
            data_valid_r   <= data_valid_s;
            parity_error_r <= parity_error_s;
            frame_error_r  <= frame_error_s;
            rx_busy_r      <= rx_busy_s;
        end
    end

    assign data         = data_r;
    assign data_valid   = data_valid_r;
    assign parity_error = parity_error_r;
    assign frame_error  = frame_error_r;
    assign rx_busy      = rx_busy_r;

endmodule
